// File: rtl/safe_pkg.sv
// Shared types and defaults for the safe-unlock datapath and its FSM bench.
package safe_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MAX = 4'd9;

  localparam int N_DIGITS_DEF       = 4;
  localparam int MAX_FAILS_DEF      = 3;
  localparam int LOCKOUT_CYCLES_DEF = 1024;

  function automatic int code_w(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/safe_entry_buffer.sv
// Keypad entry shift register: BCD filter, digit count, CLEAR priority.
module safe_entry_buffer
  import safe_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  localparam int CW    = code_w(N_DIGITS),
  localparam int CNT_W = $clog2(N_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             clear,
  input  logic             hold,
  output logic [CW-1:0]    code,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(N_DIGITS);

  logic take;

  assign full = (count == FULL_CNT);

  assign take = digit_valid && !hold &&
                !full && (digit <= DIGIT_MAX);

  always_ff @(posedge clk) begin
    if (RESET || clear) begin
      code  <= '0;
      count <= '0;
    end else if (take) begin
      code  <= (code << 4) | CW'(digit);
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/safe_code_store.sv
// Password/attempt store, compare, fail counter and lockout timer.
// Optional SAFE_MASTER_CODE_EN adds a MASTER_CODE override.
module safe_code_store
  import safe_pkg::*;
#(
  parameter int N_DIGITS       = N_DIGITS_DEF,
  parameter int MAX_FAILS      = MAX_FAILS_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
`ifdef SAFE_MASTER_CODE_EN
  ,
  parameter logic [code_w(N_DIGITS)-1:0] MASTER_CODE =
    {N_DIGITS{4'h9}}
`endif
) (
  input  logic                           clk,
  input  logic                           RESET,
  input  logic [3:0]                     DIGIT,
  input  logic                           DIGIT_VALID,
  input  logic                           CLEAR,
  input  logic                           savePW,
  input  logic                           saveAT,
  output logic                           MATCH,
  output logic                           PW_VALID,
  output logic [$clog2(N_DIGITS+1)-1:0]  ENTRY_COUNT,
  output logic                           BAD_LEN,
  output logic [$clog2(MAX_FAILS+1)-1:0] FAIL_COUNT,
  output logic                           LOCKOUT
);

  localparam int CW = code_w(N_DIGITS);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);

  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [TW-1:0] T_LOAD    = TW'(LOCKOUT_CYCLES - 1);

  logic          pw_q;
  logic          at_q;
  logic          pw_rise;
  logic          at_rise;
  logic          entry_clr;
  logic          full;
  logic          code_hit;
  logic          master_hit;
  logic [CW-1:0] code;
  logic [CW-1:0] pw_code;
  logic [TW-1:0] timer;

  // savePW wins a simultaneous rise; saveAT is dropped
  assign pw_rise   = savePW && !pw_q;
  assign at_rise   = saveAT && !at_q && !pw_rise;
  assign entry_clr = CLEAR || pw_rise || at_rise;

  assign code_hit = PW_VALID && full &&
                    (code == pw_code);

`ifdef SAFE_MASTER_CODE_EN
  assign master_hit = full && (code == MASTER_CODE);
`else
  assign master_hit = 1'b0;
`endif

  safe_entry_buffer #(
    .N_DIGITS    (N_DIGITS)
  ) u_entry (
    .clk         (clk),
    .RESET       (RESET),
    .digit       (DIGIT),
    .digit_valid (DIGIT_VALID),
    .clear       (entry_clr),
    .hold        (LOCKOUT),
    .code        (code),
    .count       (ENTRY_COUNT),
    .full        (full)
  );

  always_ff @(posedge clk) begin
    if (RESET) begin
      pw_q       <= 1'b0;
      at_q       <= 1'b0;
      pw_code    <= '0;
      timer      <= '0;
      MATCH      <= 1'b0;
      PW_VALID   <= 1'b0;
      BAD_LEN    <= 1'b0;
      FAIL_COUNT <= '0;
      LOCKOUT    <= 1'b0;
    end else begin
      pw_q    <= savePW;
      at_q    <= saveAT;
      BAD_LEN <= (pw_rise || at_rise) && !full;

      if (LOCKOUT) begin
        if (timer == '0) begin
          LOCKOUT    <= 1'b0;
          FAIL_COUNT <= '0;
        end else begin
          timer <= timer - TW'(1);
        end
      end

      unique case (1'b1)
        pw_rise: begin
          MATCH <= 1'b0;
          if (full) begin
            pw_code    <= code;
            PW_VALID   <= 1'b1;
            FAIL_COUNT <= '0;
          end
        end
        at_rise: begin
          if (master_hit) begin
            MATCH      <= 1'b1;
            FAIL_COUNT <= '0;
            LOCKOUT    <= 1'b0;
          end else if (LOCKOUT) begin
            MATCH <= 1'b0;
          end else if (code_hit) begin
            MATCH      <= 1'b1;
            FAIL_COUNT <= '0;
          end else begin
            MATCH <= 1'b0;
            if (FAIL_COUNT != FAIL_MAX)
              FAIL_COUNT <= FAIL_COUNT + FW'(1);
            if (FAIL_COUNT == FAIL_LAST) begin
              LOCKOUT <= 1'b1;
              timer   <= T_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_safe_code_store.sv
// Directed plus random bench for safe_code_store against a queue model.
module tb_safe_code_store;
  import safe_pkg::*;

  localparam int ND = N_DIGITS_DEF;
  localparam int MF = MAX_FAILS_DEF;
  localparam int LC = LOCKOUT_CYCLES_DEF;
  localparam int CNT_W = $clog2(ND + 1);
  localparam int FW = $clog2(MF + 1);

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic [3:0] DIGIT = '0;
  logic DIGIT_VALID = 1'b0;
  logic CLEAR = 1'b0;
  logic savePW = 1'b0;
  logic saveAT = 1'b0;
  logic MATCH, PW_VALID, BAD_LEN, LOCKOUT;
  logic [CNT_W-1:0] ENTRY_COUNT;
  logic [FW-1:0] FAIL_COUNT;

  safe_code_store #(
    .N_DIGITS       (ND),
    .MAX_FAILS      (MF),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .DIGIT       (DIGIT),
    .DIGIT_VALID (DIGIT_VALID),
    .CLEAR       (CLEAR),
    .savePW      (savePW),
    .saveAT      (saveAT),
    .MATCH       (MATCH),
    .PW_VALID    (PW_VALID),
    .ENTRY_COUNT (ENTRY_COUNT),
    .BAD_LEN     (BAD_LEN),
    .FAIL_COUNT  (FAIL_COUNT),
    .LOCKOUT     (LOCKOUT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag,
                     logic [31:0] got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d",
               tag, got, exp);
    end
  endtask

  // Reference model: digits as a queue, stored code as a queue
  int q[$];
  int pw[$];
  bit m_pwv, m_match, m_bad, m_lock;
  bit pw_p, at_p;
  int m_fail, m_left;

  function automatic bit same(int a[$], int b[$]);
    if (a.size() != ND || b.size() != ND) return 0;
    for (int i = 0; i < ND; i++)
      if (a[i] != b[i]) return 0;
    return 1;
  endfunction

  function automatic bit is_master(int a[$]);
`ifdef SAFE_MASTER_CODE_EN
    if (a.size() != ND) return 0;
    foreach (a[i]) if (a[i] != 9) return 0;
    return 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    bit pr, ar, full, was_lock, phit, mhit;
    if (RESET) begin
      q.delete(); pw.delete();
      m_pwv = 0; m_match = 0; m_bad = 0;
      m_lock = 0; m_left = 0; m_fail = 0;
      pw_p = 0; at_p = 0;
      return;
    end
    pr = savePW && !pw_p;
    ar = saveAT && !at_p && !pr;
    pw_p = savePW;
    at_p = saveAT;
    full = (q.size() == ND);
    was_lock = m_lock;
    phit = m_pwv && same(q, pw);
    mhit = is_master(q);
    m_bad = (pr || ar) && !full;
    if (m_lock) begin
      if (m_left == 0) begin
        m_lock = 0; m_fail = 0;
      end else m_left--;
    end
    if (pr) begin
      m_match = 0;
      if (full) begin
        pw = q; m_pwv = 1; m_fail = 0;
      end
    end else if (ar) begin
      if (mhit) begin
        m_match = 1; m_fail = 0; m_lock = 0;
      end else if (was_lock) begin
        m_match = 0;
      end else if (phit) begin
        m_match = 1; m_fail = 0;
      end else begin
        m_match = 0;
        if (m_fail < MF) m_fail++;
        if (m_fail == MF) begin
          m_lock = 1; m_left = LC - 1;
        end
      end
    end
    if (CLEAR || pr || ar) q.delete();
    else if (DIGIT_VALID && DIGIT <= 9 &&
             q.size() < ND && !was_lock)
      q.push_back(int'(DIGIT));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("MATCH", MATCH, m_match);
    chk("PW_VALID", PW_VALID, m_pwv);
    chk("ENTRY_COUNT", ENTRY_COUNT, q.size());
    chk("BAD_LEN", BAD_LEN, m_bad);
    chk("FAIL_COUNT", FAIL_COUNT, m_fail);
    chk("LOCKOUT", LOCKOUT, m_lock);
  endtask

  task automatic press(int d);
    DIGIT = 4'(d);
    DIGIT_VALID = 1'b1;
    tick();
    DIGIT_VALID = 1'b0;
    tick();
  endtask

  task automatic enter(int c);
    for (int i = 0; i < ND; i++)
      press((c >> (4 * (ND - 1 - i))) & 15);
  endtask

  task automatic store_pw(int c);
    enter(c);
    savePW = 1'b1;
    repeat (3) tick();
    savePW = 1'b0;
    tick();
  endtask

  task automatic attempt(int c);
    enter(c);
    saveAT = 1'b1;
    tick();
  endtask

  task automatic release_at();
    repeat (2) tick();
    saveAT = 1'b0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_match", MATCH, 0);
    chk("rst_pwv", PW_VALID, 0);
    chk("rst_cnt", ENTRY_COUNT, 0);
    chk("rst_lock", LOCKOUT, 0);
    RESET = 1'b0;
    tick();

    store_pw('h1234);
    chk("pw_stored", PW_VALID, 1);
    chk("pw_cnt0", ENTRY_COUNT, 0);
    attempt('h1234);
    chk("match_1234", MATCH, 1);
    chk("fail0", FAIL_COUNT, 0);
    release_at();

    press(5); press(6);
    savePW = 1'b1;
    tick();
    chk("badlen_pulse", BAD_LEN, 1);
    tick();
    chk("badlen_once", BAD_LEN, 0);
    chk("short_pwv", PW_VALID, 1);
    chk("short_cnt", ENTRY_COUNT, 0);
    savePW = 1'b0;
    tick();

    for (int n = 1; n <= MF; n++) begin
      attempt('h0000);
      chk("fail_inc", FAIL_COUNT, n);
      chk("nomatch", MATCH, 0);
      release_at();
    end
    chk("locked", LOCKOUT, 1);
    press(7);
    chk("lock_ignores", ENTRY_COUNT, 0);
    repeat (LC) tick();
    chk("unlocked", LOCKOUT, 0);
    chk("unlock_fail0", FAIL_COUNT, 0);
    attempt('h1234);
    chk("match_after", MATCH, 1);
    release_at();

    press('hA);
    chk("digit_A", ENTRY_COUNT, 0);
    enter('h1234);
    press(5);
    chk("fifth_dig", ENTRY_COUNT, ND);
    CLEAR = 1'b1;
    DIGIT = 4'd3;
    DIGIT_VALID = 1'b1;
    tick();
    CLEAR = 1'b0;
    DIGIT_VALID = 1'b0;
    chk("clr_wins", ENTRY_COUNT, 0);
    tick();

    enter('h4321);
    savePW = 1'b1;
    saveAT = 1'b1;
    tick();
    chk("both_match0", MATCH, 0);
    chk("both_pwv", PW_VALID, 1);
    savePW = 1'b0;
    saveAT = 1'b0;
    tick();
    enter('h4321);
    DIGIT = 4'd7;
    DIGIT_VALID = 1'b1;
    saveAT = 1'b1;
    tick();
    DIGIT_VALID = 1'b0;
    chk("dig_drop", MATCH, 1);
    chk("dig_drop_cnt", ENTRY_COUNT, 0);
    release_at();

    for (int c = 0; c < 4000; c++) begin
      RESET = ($urandom_range(0, 299) == 0);
      CLEAR = ($urandom_range(0, 24) == 0);
      DIGIT_VALID = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        DIGIT = 4'($urandom_range(0, 15));
      else
        DIGIT = 4'($urandom_range(1, 4));
      if ($urandom_range(0, 39) == 0)
        savePW = ~savePW;
      if ($urandom_range(0, 11) == 0)
        saveAT = ~saveAT;
      tick();
    end

`ifdef SAFE_MASTER_CODE_EN
    RESET = 1'b1;
    CLEAR = 1'b0;
    DIGIT_VALID = 1'b0;
    savePW = 1'b0;
    saveAT = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    attempt('h9999);
    chk("master_nopw", MATCH, 1);
    release_at();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
